// File: rtl/xadc_joystick_sampler.sv
// ============================================================================
//  Module      : xadc_joystick_sampler
//  Description : Sequences XADC DRP reads of the four joystick auxiliary
//                channels (p1 x, p1 y, p2 x, p2 y). Each read is triggered
//                by an XADC end-of-conversion pulse. After all four channels
//                have been read, the samples are turned into per-player
//                movement deltas and kick requests. The results are
//                registered once per complete scan.
//
//  Ports       : clk        - system clock (XADC dclk)
//                rst        - synchronous active-high reset
//                eoc        - XADC end-of-conversion pulse
//                drdy       - XADC DRP data ready
//                do_in      - XADC DRP read data (sample in [15:4])
//                daddr      - DRP address of the current channel
//                den        - DRP enable, one-cycle pulse per read
//                p1_dx/p2_dx- signed x delta (-1/0/+1)
//                p1_dy/p2_dy- y delta (0/+1)
//                p1_kick/p2_kick - kick request
//                scan_valid - one-cycle pulse after outputs update
//                err        - sticky DRP read timeout flag
//
//  Options     : JOY_KICK_PULSE_EN - when defined, a kick is a one-scan
//                pulse on the scan where the up-count first saturates.
//                When undefined, a kick stays high while the count is saturated.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadc_joystick_sampler #(
    parameter int DEADBAND     = 256,
    parameter int KICK_CONFIRM = 2,
    parameter int DRDY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic [6:0]  daddr,
    output logic        den,
    output logic [10:0] p1_dx,
    output logic [10:0] p1_dy,
    output logic        p1_kick,
    output logic [10:0] p2_dx,
    output logic [10:0] p2_dy,
    output logic        p2_kick,
    output logic        scan_valid,
    output logic        err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam int c_center_int = 2048;
    localparam int c_hi_int     = c_center_int + DEADBAND;
    localparam int c_lo_int     = c_center_int - DEADBAND;

    // Thresholds in 13-bit unsigned space. A lower threshold at or below
    // zero clamps to 0 so that "below" can never be true (no wrap-around).
    localparam logic [12:0] c_hi  = 13'(c_hi_int);
    localparam logic [12:0] c_lo  = (c_lo_int > 0) ? 13'(c_lo_int) : 13'd0;
    localparam logic [11:0] c_mid = 12'd2048;
    localparam logic [3:0]  c_kc  = 4'(KICK_CONFIRM);
    localparam logic [9:0]  c_tmo = 10'(DRDY_TIMEOUT);

    localparam logic [10:0] c_plus1  = 11'd1;
    localparam logic [10:0] c_minus1 = 11'h7FF;

    // Channel index -> DRP address
    function automatic logic [6:0] chan_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    chan_addr = 7'h16;   // p1 x (VAUX6)
            2'd1:    chan_addr = 7'h1E;   // p1 y (VAUX14)
            2'd2:    chan_addr = 7'h17;   // p2 x (VAUX7)
            default: chan_addr = 7'h1F;   // p2 y (VAUX15)
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [1:0]  r_idx;
    logic [9:0]  r_tmo;
    logic [11:0] r_slot [4];
    logic [3:0]  r_kcnt [2];
    logic [10:0] r_dx   [2];
    logic [10:0] r_dy   [2];
    logic        r_kick [2];
    logic        r_scan_valid;
    logic        r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [2:0]  w_state_nxt;
    logic        w_rd_store;
    logic        w_rd_timeout;
    logic [10:0] w_dx_nxt   [2];
    logic [10:0] w_dy_nxt   [2];
    logic [3:0]  w_kcnt_nxt [2];
    logic        w_kick_nxt [2];
    logic        w_do_unused;

    // The low nibble of the DRP word carries no sample data.
    assign w_do_unused = ^do_in[3:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (eoc) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (drdy || (r_tmo == c_tmo)) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_nxt = (r_idx == 2'd3) ? S_UPDATE : S_IDLE;
            end
            S_UPDATE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        daddr        = chan_addr(r_idx);
        den          = (r_state == S_ISSUE);
        // drdy wins over a timeout landing in the same cycle
        w_rd_store   = (r_state == S_WAIT) && drdy;
        w_rd_timeout = (r_state == S_WAIT) && !drdy && (r_tmo == c_tmo);
    end

    // ------------------------------------------------------------------
    // Per-player sample mapping (x slot = 2p, y slot = 2p+1)
    // ------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_player
        logic w_x_hi;
        logic w_x_lo;
        logic w_y_hi;
        logic w_y_up;

        assign w_x_hi = {1'b0, r_slot[2*p]}   > c_hi;
        assign w_x_lo = {1'b0, r_slot[2*p]}   < c_lo;
        assign w_y_hi = {1'b0, r_slot[2*p+1]} > c_hi;
        assign w_y_up = {1'b0, r_slot[2*p+1]} < c_lo;

        assign w_dx_nxt[p] = w_x_hi ? c_plus1 : (w_x_lo ? c_minus1 : 11'd0);
        assign w_dy_nxt[p] = w_y_hi ? c_plus1 : 11'd0;

        // Up-count saturates at the confirm threshold; any non-up scan clears it.
        assign w_kcnt_nxt[p] = !w_y_up               ? 4'd0 :
                               (r_kcnt[p] == c_kc)   ? c_kc :
                                                       r_kcnt[p] + 4'd1;

`ifdef JOY_KICK_PULSE_EN
        // Fire only on the scan where the count first reaches saturation.
        assign w_kick_nxt[p] = (w_kcnt_nxt[p] == c_kc) && (r_kcnt[p] != c_kc);
`else
        assign w_kick_nxt[p] = (w_kcnt_nxt[p] == c_kc);
`endif
    end

    // ------------------------------------------------------------------
    // Datapath: index, timeout counter, sample slots, results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 2'd0;
            r_tmo        <= 10'd0;
            r_scan_valid <= 1'b0;
            r_err        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= c_mid;
            end
            for (int p = 0; p < 2; p++) begin
                r_kcnt[p] <= 4'd0;
                r_dx[p]   <= 11'd0;
                r_dy[p]   <= 11'd0;
                r_kick[p] <= 1'b0;
            end
        end else begin
            r_scan_valid <= 1'b0;

            case (r_state)
                S_ISSUE: begin
                    r_tmo <= 10'd0;
                end
                S_WAIT: begin
                    if (!w_rd_store && !w_rd_timeout) begin
                        r_tmo <= r_tmo + 10'd1;
                    end
                end
                S_NEXT: begin
                    // 2-bit index wraps 3 -> 0 as the scan completes
                    r_idx <= r_idx + 2'd1;
                end
                S_UPDATE: begin
                    r_scan_valid <= 1'b1;
                    for (int p = 0; p < 2; p++) begin
                        r_dx[p]   <= w_dx_nxt[p];
                        r_dy[p]   <= w_dy_nxt[p];
                        r_kcnt[p] <= w_kcnt_nxt[p];
                        r_kick[p] <= w_kick_nxt[p];
                    end
                end
                default: begin
                end
            endcase

            if (w_rd_store) begin
                r_slot[r_idx] <= do_in[15:4];
            end
            if (w_rd_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output ports
    // ------------------------------------------------------------------
    assign p1_dx      = r_dx[0];
    assign p1_dy      = r_dy[0];
    assign p1_kick    = r_kick[0];
    assign p2_dx      = r_dx[1];
    assign p2_dy      = r_dy[1];
    assign p2_kick    = r_kick[1];
    assign scan_valid = r_scan_valid;
    assign err        = r_err;

endmodule

`default_nettype wire
